// File: rtl/posit_add_align.sv
// Posit (ES=2) adder front end: orders an operand pair by magnitude, then
// right-aligns the smaller mantissa to the larger scale with a sticky bit.
module posit_add_align #(
    parameter int unsigned GUARD_BITS = 3,
    localparam int unsigned FW = 27,
    localparam int unsigned PW = 38,
    localparam int unsigned MW = 1 + FW + GUARD_BITS
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_a,
    input  logic [PW-1:0] in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sgn_lg,
    output logic          out_sgn_sm,
    output logic [7:0]    out_scale,
    output logic [MW-1:0] out_mant_lg,
    output logic [MW-1:0] out_mant_sm,
    output logic          out_sub,
    output logic          out_inf,
    output logic          out_zero
);

    typedef struct packed {
        logic          sgn;
        logic [7:0]    scale;
        logic [FW-1:0] frac;
        logic          inf;
        logic          zero;
    } posit_t;

    posit_t        a, b, lg, sm;
    logic [MW-1:0] mant_a, mant_b, mant_lg_c, mant_sm_c;
    logic          a_larger, is_inf, is_zero, kill;
    logic [8:0]    diff_c;

    logic          s1_valid, s2_load, s1_load;
    logic          s1_sgn_lg, s1_sgn_sm, s1_inf, s1_zero;
    logic [7:0]    s1_scale;
    logic [8:0]    s1_diff;
    logic [MW-1:0] s1_mant_lg, s1_mant_sm;

    logic [MW-1:0] shifted, mask, mant_sm_al;
    logic          sticky;

    assign a = in_a;
    assign b = in_b;

    assign s2_load  = ~out_valid | out_ready;
    assign s1_load  = ~s1_valid | s2_load;
    assign in_ready = s1_load;

    // Stage 1: build mantissas, pick larger magnitude, form 9-bit scale difference
    always_comb begin
        mant_a   = a.zero ? '0 : {1'b1, a.frac, {GUARD_BITS{1'b0}}};
        mant_b   = b.zero ? '0 : {1'b1, b.frac, {GUARD_BITS{1'b0}}};
        a_larger = 1'b1;
        if (a.zero != b.zero)
            a_larger = b.zero;
        else if (a.scale != b.scale)
            a_larger = $signed(a.scale) > $signed(b.scale);
        else
            a_larger = mant_a >= mant_b;
        lg        = a_larger ? a : b;
        sm        = a_larger ? b : a;
        mant_lg_c = a_larger ? mant_a : mant_b;
        mant_sm_c = a_larger ? mant_b : mant_a;
        diff_c    = {lg.scale[7], lg.scale} - {sm.scale[7], sm.scale};
        is_inf    = a.inf | b.inf;
        is_zero   = a.zero & b.zero & ~is_inf;
        kill      = is_inf | is_zero;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid   <= 1'b0;
            s1_sgn_lg  <= 1'b0;
            s1_sgn_sm  <= 1'b0;
            s1_scale   <= '0;
            s1_diff    <= '0;
            s1_mant_lg <= '0;
            s1_mant_sm <= '0;
            s1_inf     <= 1'b0;
            s1_zero    <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sgn_lg  <= kill ? 1'b0 : lg.sgn;
                s1_sgn_sm  <= kill ? 1'b0 : sm.sgn;
                s1_scale   <= kill ? '0 : lg.scale;
                s1_diff    <= kill ? '0 : diff_c;
                s1_mant_lg <= kill ? '0 : mant_lg_c;
                s1_mant_sm <= kill ? '0 : mant_sm_c;
                s1_inf     <= is_inf;
                s1_zero    <= is_zero;
            end
        end
    end

    // Stage 2: right shift with sticky; a negative difference only arises with a zero mantissa
    always_comb begin
        shifted = '0;
        mask    = '0;
        sticky  = 1'b0;
        if (s1_diff >= 9'(MW)) begin
            sticky = |s1_mant_sm;
        end else begin
            shifted = s1_mant_sm >> s1_diff;
            mask    = ~({MW{1'b1}} << s1_diff);
            sticky  = |(s1_mant_sm & mask);
        end
        mant_sm_al = shifted | MW'(sticky);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_sgn_lg  <= 1'b0;
            out_sgn_sm  <= 1'b0;
            out_scale   <= '0;
            out_mant_lg <= '0;
            out_mant_sm <= '0;
            out_sub     <= 1'b0;
            out_inf     <= 1'b0;
            out_zero    <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sgn_lg  <= s1_sgn_lg;
                out_sgn_sm  <= s1_sgn_sm;
                out_scale   <= s1_scale;
                out_mant_lg <= s1_mant_lg;
                out_mant_sm <= mant_sm_al;
                out_sub     <= s1_sgn_lg ^ s1_sgn_sm;
                out_inf     <= s1_inf;
                out_zero    <= s1_zero;
            end
        end
    end

endmodule

// File: tb/tb_posit_add_align.sv
// Directed bench for posit_add_align: alignment, swap, sticky, specials,
// streaming under backpressure and reset in flight.
module tb_posit_add_align;

    localparam int unsigned MW = 31;

    logic          clk, reset_n, in_valid, in_ready, out_valid, out_ready;
    logic [37:0]   in_a, in_b;
    logic          out_sgn_lg, out_sgn_sm, out_sub, out_inf, out_zero;
    logic [7:0]    out_scale;
    logic [MW-1:0] out_mant_lg, out_mant_sm;

    int checks = 0;
    int errors = 0;

    posit_add_align #(.GUARD_BITS(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sgn_lg(out_sgn_lg), .out_sgn_sm(out_sgn_sm), .out_scale(out_scale),
        .out_mant_lg(out_mant_lg), .out_mant_sm(out_mant_sm),
        .out_sub(out_sub), .out_inf(out_inf), .out_zero(out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [37:0] mk(input logic sgn, input logic [7:0] sc,
                                       input logic [26:0] fr, input logic inf, input logic zero);
        return {sgn, sc, fr, inf, zero};
    endfunction

    // One pair through an idle pipeline; lat counts cycles from presentation to out_valid
    task automatic run_pair(input logic [37:0] a, input logic [37:0] b, output int lat);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_a = a; in_b = b; in_valid = 1'b1; lat = 0;
        @(posedge clk); #1;
        in_valid = 1'b0; lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        checks++; if (out_mant_lg !== '0 || out_mant_sm !== '0) begin errors++; $display("FAIL rst_mant got %h/%h want 0", out_mant_lg, out_mant_sm); end
        checks++; if (out_scale !== 8'h00 || out_inf !== 1'b0 || out_zero !== 1'b0) begin errors++; $display("FAIL rst_fields got %h %b %b want 0", out_scale, out_inf, out_zero); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_valid got %b want 0", out_valid); end
    endtask

    task automatic test_align();
        int lat;
        run_pair(mk(0, 8'd4, 27'd0, 0, 0), mk(0, 8'd1, 27'd0, 0, 0), lat);
        checks++; if (lat !== 2 || out_valid !== 1'b1) begin errors++; $display("FAIL align_latency got %0d want 2", lat); end
        checks++; if (out_scale !== 8'd4) begin errors++; $display("FAIL align_scale got %0d want 4", out_scale); end
        checks++; if (out_mant_lg !== 31'h40000000) begin errors++; $display("FAIL align_mant_lg got %h want 40000000", out_mant_lg); end
        checks++; if (out_mant_sm !== 31'h08000000) begin errors++; $display("FAIL align_mant_sm got %h want 08000000", out_mant_sm); end
        checks++; if (out_sub !== 1'b0) begin errors++; $display("FAIL align_sub got %b want 0", out_sub); end
    endtask

    task automatic test_swap_sticky();
        int lat;
        run_pair(mk(0, 8'hFD, 27'd1, 0, 0), mk(1, 8'd40, 27'd0, 0, 0), lat);
        checks++; if (out_sgn_lg !== 1'b1 || out_sgn_sm !== 1'b0) begin errors++; $display("FAIL swap_sgn got %b%b want 10", out_sgn_lg, out_sgn_sm); end
        checks++; if (out_scale !== 8'd40) begin errors++; $display("FAIL swap_scale got %0d want 40", out_scale); end
        checks++; if (out_mant_sm !== 31'h00000001) begin errors++; $display("FAIL swap_sticky got %h want 00000001", out_mant_sm); end
        checks++; if (out_sub !== 1'b1) begin errors++; $display("FAIL swap_sub got %b want 1", out_sub); end
        // partial shift with nonzero bits lost: 0x40000008 >> 4 plus sticky
        run_pair(mk(0, 8'd0, 27'd1, 0, 0), mk(0, 8'd4, 27'd0, 0, 0), lat);
        checks++; if (out_mant_sm !== 31'h04000001) begin errors++; $display("FAIL partial_sticky got %h want 04000001", out_mant_sm); end
        // extreme difference 255 must not wrap
        run_pair(mk(0, 8'h80, 27'd0, 0, 0), mk(0, 8'h7F, 27'd0, 0, 0), lat);
        checks++; if (out_scale !== 8'h7F || out_mant_sm !== 31'h00000001) begin errors++; $display("FAIL diff255 got %h/%h want 7f/00000001", out_scale, out_mant_sm); end
    endtask

    task automatic test_equal_scale();
        int lat;
        run_pair(mk(0, 8'd2, 27'h1, 0, 0), mk(0, 8'd2, 27'h2, 0, 0), lat);
        checks++; if (out_mant_lg !== 31'h40000010) begin errors++; $display("FAIL eq_mant_lg got %h want 40000010", out_mant_lg); end
        checks++; if (out_mant_sm !== 31'h40000008) begin errors++; $display("FAIL eq_mant_sm got %h want 40000008", out_mant_sm); end
        checks++; if (out_scale !== 8'd2) begin errors++; $display("FAIL eq_scale got %0d want 2", out_scale); end
    endtask

    task automatic test_specials();
        int lat;
        run_pair(mk(1, 8'd5, 27'h3, 1, 0), mk(0, 8'd1, 27'h0, 0, 0), lat);
        checks++; if (out_inf !== 1'b1 || out_zero !== 1'b0) begin errors++; $display("FAIL inf_flags got %b%b want 10", out_inf, out_zero); end
        checks++; if (out_mant_lg !== '0 || out_mant_sm !== '0 || out_scale !== 8'h00) begin errors++; $display("FAIL inf_data got %h %h %h want 0", out_mant_lg, out_mant_sm, out_scale); end
        checks++; if (out_sgn_lg !== 1'b0 || out_sgn_sm !== 1'b0 || out_sub !== 1'b0) begin errors++; $display("FAIL inf_sgn got %b%b%b want 000", out_sgn_lg, out_sgn_sm, out_sub); end
        run_pair(mk(1, 8'd6, 27'h0, 0, 1), mk(0, 8'd2, 27'h0, 0, 1), lat);
        checks++; if (out_zero !== 1'b1 || out_inf !== 1'b0) begin errors++; $display("FAIL zero_flags got %b%b want 10", out_zero, out_inf); end
        checks++; if (out_mant_lg !== '0 || out_scale !== 8'h00 || out_sgn_lg !== 1'b0) begin errors++; $display("FAIL zero_data got %h %h %b want 0", out_mant_lg, out_scale, out_sgn_lg); end
        // one operand zero with larger encoded scale: nonzero operand still wins
        run_pair(mk(0, 8'd10, 27'h0, 0, 1), mk(1, 8'd3, 27'h4000000, 0, 0), lat);
        checks++; if (out_mant_lg !== 31'h60000000 || out_scale !== 8'd3) begin errors++; $display("FAIL onezero_lg got %h/%0d want 60000000/3", out_mant_lg, out_scale); end
        checks++; if (out_mant_sm !== '0 || out_zero !== 1'b0 || out_sgn_lg !== 1'b1) begin errors++; $display("FAIL onezero_sm got %h %b %b want 0 0 1", out_mant_sm, out_zero, out_sgn_lg); end
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            if (c < 4) begin
                in_valid = 1'b1;
                in_a = mk(0, 8'(20 + c), 27'd0, 0, 0);
                in_b = mk(1, 8'(18 + c), 27'd0, 0, 0);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            exp_v = (c >= 2 && c < 6);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cyc %0d got %b want 1", c, in_ready); end
            checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL b2b_valid cyc %0d got %b want %b", c, out_valid, exp_v); end
            if (exp_v) begin
                checks++;
                if (out_scale !== 8'(20 + c - 2) || out_mant_sm !== 31'h10000000 || out_sub !== 1'b1) begin
                    errors++; $display("FAIL b2b_data cyc %0d got %0d %h %b want %0d 10000000 1", c, out_scale, out_mant_sm, out_sub, 20 + c - 2);
                end
            end
        end
    endtask

    task automatic test_stream();
        int          acc = 0;
        int          del = 0;
        int          cyc = 0;
        logic        stall = 1'b0;
        logic        exp_rdy;
        logic [3:0]  pat = 4'b1001;
        logic [7:0]  h_scale = '0;
        logic [30:0] h_sm = '0;
        while (del < 8 && cyc < 200) begin
            @(posedge clk); #1;
            out_ready = pat[cyc[1:0]];
            if (acc < 8) begin
                in_valid = 1'b1;
                in_a = mk(0, 8'(acc), 27'd0, 0, 0);
                in_b = mk(0, 8'd0, 27'd0, 0, 0);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_scale !== h_scale || out_mant_sm !== h_sm) begin
                    errors++; $display("FAIL stream_hold cyc %0d got %b %h %h want 1 %h %h", cyc, out_valid, out_scale, out_mant_sm, h_scale, h_sm);
                end
            end
            exp_rdy = !((acc - del) == 2 && !out_ready);
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL stream_in_ready cyc %0d got %b want %b", cyc, in_ready, exp_rdy); end
            if (out_valid && out_ready) begin
                checks++;
                if (out_scale !== 8'(del) || out_mant_lg !== 31'h40000000 || out_mant_sm !== (31'h40000000 >> del)) begin
                    errors++; $display("FAIL stream_data item %0d got %0d %h %h", del, out_scale, out_mant_lg, out_mant_sm);
                end
                del++;
            end
            stall = out_valid && !out_ready;
            h_scale = out_scale;
            h_sm = out_mant_sm;
            if (in_valid && in_ready) acc++;
            cyc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (del !== 8 || acc !== 8) begin errors++; $display("FAIL stream_count got %0d out %0d in want 8", del, acc); end
    endtask

    task automatic test_reset_mid();
        int lat;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = mk(0, 8'd11, 27'd0, 0, 0); in_b = mk(0, 8'd0, 27'd0, 0, 0);
        @(posedge clk); #1;
        in_a = mk(0, 8'd12, 27'd0, 0, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL rmid_full got %b %b want 1 0", out_valid, in_ready); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rmid_async got %b %b want 0 1", out_valid, in_ready); end
        checks++; if (out_scale !== 8'h00 || out_mant_lg !== '0) begin errors++; $display("FAIL rmid_data got %h %h want 0", out_scale, out_mant_lg); end
        @(posedge clk); #1;
        reset_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_ghost cyc %0d got %b want 0", i, out_valid); end
        end
        run_pair(mk(0, 8'd13, 27'd0, 0, 0), mk(0, 8'd13, 27'd0, 0, 1), lat);
        checks++; if (lat !== 2 || out_scale !== 8'd13) begin errors++; $display("FAIL rmid_first got lat %0d scale %0d want 2 13", lat, out_scale); end
    endtask

    initial begin
        test_reset();
        test_align();
        test_swap_sticky();
        test_equal_scale();
        test_specials();
        test_back_to_back();
        test_stream();
        test_reset_mid();
        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
